// File: rtl/csr_seq_ctrl_pkg.sv
// Shared definitions for the convolution configuration sequencer.
//   state_t          : job FSM encoding (3 bits), also visible on the debug port
//   STAT_*_BIT       : bit positions inside the host-visible status register
//   status_addr()    : host address of the status register (top of the map)
package csr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COMMIT = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int STAT_BUSY_BIT      = 0;
  localparam int STAT_ERR_ADDR_BIT  = 1;
  localparam int STAT_ERR_START_BIT = 2;
  localparam int STAT_TIMEOUT_BIT   = 3;
  localparam int STAT_ERR_DONE_BIT  = 4;

  // The status register always sits at the highest host address.
  function automatic int status_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/csr_seq_ctrl_if.sv
// Host-side register bus of the configuration sequencer.
//   host_wr_valid/host_wr_ready : write handshake
//   host_addr/host_wdata        : write address and data
//   host_rd_addr/host_rdata     : read address and registered read data
// Handshake: a write transfers on a rising edge where host_wr_valid and
// host_wr_ready are both high; address and data must be stable while
// host_wr_valid is high. Reads have no handshake: host_rdata reflects the
// address presented in the previous cycle.
interface csr_seq_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_wr_valid, host_addr, host_wdata, host_rd_addr,
    input  host_wr_ready, host_rdata
  );

  modport slave (
    input  host_wr_valid, host_addr, host_wdata, host_rd_addr,
    output host_wr_ready, host_rdata
  );
endinterface

// File: rtl/csr_seq_ctrl_bank.sv
// Bank of NUM_REGS configuration registers, DATA_W bits each.
//   clk, rst : clock, synchronous active-high clear
//   we       : per-entry write enable
//   d        : per-entry write data, entry i at [i*DATA_W +: DATA_W]
//   q        : register contents, same packing as d
module csr_seq_ctrl_bank #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS-1:0]        we,
  input  logic [NUM_REGS*DATA_W-1:0] d,
  output logic [NUM_REGS*DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we[i]) q[i*DATA_W +: DATA_W] <= d[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/csr_seq_ctrl.sv
// Configuration sequencer for the convolution datapath.
// The host fills a shadow bank; a start request copies it to the active bank
// (cfg_out) in one cycle, pulses dp_start, then waits for dp_done under a
// watchdog and reports the outcome in a sticky status register.
//   clk, rst   : clock, synchronous active-high reset
//   host       : host register bus (slave side)
//   start      : level request to commit and launch, honoured in IDLE only
//   busy       : high from COMMIT through DONE
//   done       : one-cycle pulse at the end of a job
//   dp_start   : one-cycle launch pulse to the datapath
//   dp_done    : completion pulse from the datapath
//   cfg_out    : active bank, reg i at [i*DATA_W +: DATA_W]
//   dbg_state  : current FSM state
module csr_seq_ctrl
  import csr_seq_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  csr_seq_ctrl_if.slave              host,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       dp_start,
  input  logic                       dp_done,
  output logic [NUM_REGS*DATA_W-1:0] cfg_out,
  output logic [2:0]                 dbg_state
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] REG_LIMIT   = ADDR_W'(NUM_REGS);
  // The watchdog holds (RUN cycles - 1); seeing this value means the edge
  // that ends the current cycle takes it to all-ones, i.e. the limit.
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t state_q, state_d;
  logic   commit;
  logic   wr_fire;
  logic   wd_expire;
  logic [TIMEOUT_W-1:0] wd_q;

  logic [NUM_REGS-1:0]        shadow_we;
  logic [NUM_REGS*DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0]          rd_reg;
  logic [DATA_W-1:0]          status_w;

  logic err_addr_q, err_start_q, timeout_q, err_done_q;
  logic status_wr;
  logic set_addr, set_start, set_timeout, set_done;
  logic clr_addr, clr_start, clr_timeout, clr_done;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign wd_expire = (state_q == ST_RUN) && (wd_q == WD_LAST);

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (dp_done || wd_expire) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy               = 1'b0;
    commit             = 1'b0;
    dp_start           = 1'b0;
    done               = 1'b0;
    host.host_wr_ready = 1'b1;
    case (state_q)
      ST_COMMIT: begin
        busy               = 1'b1;
        commit             = 1'b1;
        // Shadow is being copied this cycle; hold off all host writes.
        host.host_wr_ready = 1'b0;
      end
      ST_LAUNCH: begin
        busy     = 1'b1;
        dp_start = 1'b1;
      end
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------- Watchdog ----------------
  always_ff @(posedge clk) begin
    if (rst)                       wd_q <= '0;
    else if (state_q == ST_LAUNCH) wd_q <= '0;
    else if (state_q == ST_RUN)    wd_q <= wd_q + 1'b1;
  end

  // ---------------- Register banks ----------------
  assign wr_fire = host.host_wr_valid && host.host_wr_ready;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_we[i] = wr_fire && (host.host_addr == ADDR_W'(i));
    end
  end

  csr_seq_ctrl_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_shadow (
    .clk (clk),
    .rst (rst),
    .we  (shadow_we),
    .d   ({NUM_REGS{host.host_wdata}}),
    .q   (shadow_q)
  );

  // Active bank reloads all entries at once from the shadow bank.
  csr_seq_ctrl_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_active (
    .clk (clk),
    .rst (rst),
    .we  ({NUM_REGS{commit}}),
    .d   (shadow_q),
    .q   (cfg_out)
  );

  // ---------------- Status register ----------------
  assign status_wr   = wr_fire && (host.host_addr == STATUS_ADDR);
  assign set_addr    = wr_fire && (host.host_addr >= REG_LIMIT) &&
                       (host.host_addr != STATUS_ADDR);
  assign set_start   = start && (state_q != ST_IDLE);
  assign set_timeout = wd_expire && !dp_done;   // a same-cycle dp_done wins
  assign set_done    = dp_done && (state_q != ST_RUN);
  assign clr_addr    = status_wr && host.host_wdata[STAT_ERR_ADDR_BIT];
  assign clr_start   = status_wr && host.host_wdata[STAT_ERR_START_BIT];
  assign clr_timeout = status_wr && host.host_wdata[STAT_TIMEOUT_BIT];
  assign clr_done    = status_wr && host.host_wdata[STAT_ERR_DONE_BIT];

  // Sticky error bits; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q  <= 1'b0;
      err_start_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_done_q  <= 1'b0;
    end else begin
      err_addr_q  <= set_addr    | (err_addr_q  & ~clr_addr);
      err_start_q <= set_start   | (err_start_q & ~clr_start);
      timeout_q   <= set_timeout | (timeout_q   & ~clr_timeout);
      err_done_q  <= set_done    | (err_done_q  & ~clr_done);
    end
  end

  always_comb begin
    status_w                     = '0;
    status_w[STAT_BUSY_BIT]      = busy;
    status_w[STAT_ERR_ADDR_BIT]  = err_addr_q;
    status_w[STAT_ERR_START_BIT] = err_start_q;
    status_w[STAT_TIMEOUT_BIT]   = timeout_q;
    status_w[STAT_ERR_DONE_BIT]  = err_done_q;
  end

  // ---------------- Host read path ----------------
  always_comb begin
    rd_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (host.host_rd_addr == ADDR_W'(i)) rd_reg = shadow_q[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                host.host_rdata <= '0;
    else if (host.host_rd_addr == STATUS_ADDR) host.host_rdata <= status_w;
    else                                    host.host_rdata <= rd_reg;
  end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Self-checking bench for csr_seq_ctrl: randomized register contents and job
// timing, checked against a register/status model kept in plain arrays.
`timescale 1ns/1ps
module tb_csr_seq_ctrl;
  import csr_seq_ctrl_pkg::*;

  localparam int NUM_REGS  = 8;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int TIMEOUT_W = 4;
  localparam int RUN_LIMIT = (1 << TIMEOUT_W) - 1;
  localparam int STAT_A    = (1 << ADDR_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       start, dp_done;
  logic                       busy, done, dp_start;
  logic [NUM_REGS*DATA_W-1:0] cfg_out;
  logic [2:0]                 dbg_state;

  csr_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_bus ();

  csr_seq_ctrl #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_bus),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dp_start  (dp_start),
    .dp_done   (dp_done),
    .cfg_out   (cfg_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_shadow[NUM_REGS];
  logic [DATA_W-1:0] exp_active[NUM_REGS];
  bit exp_err_addr, exp_err_start, exp_timeout, exp_err_done;

  function automatic logic [DATA_W-1:0] exp_status(input bit busy_b);
    return {11'b0, exp_err_done, exp_timeout, exp_err_start, exp_err_addr, busy_b};
  endfunction

  function automatic logic [NUM_REGS*DATA_W-1:0] packed_active();
    logic [NUM_REGS*DATA_W-1:0] r;
    for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = exp_active[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_shadow[i] = '0;
      exp_active[i] = '0;
    end
    exp_err_addr = 0; exp_err_start = 0; exp_timeout = 0; exp_err_done = 0;
  endfunction

  // Accepted host write: W1C clears are applied before any same-cycle sets.
  function automatic void model_write(input int addr, input logic [DATA_W-1:0] data);
    if (addr < NUM_REGS) exp_shadow[addr] = data;
    else if (addr == STAT_A) begin
      if (data[1]) exp_err_addr  = 0;
      if (data[2]) exp_err_start = 0;
      if (data[3]) exp_timeout   = 0;
      if (data[4]) exp_err_done  = 0;
    end else exp_err_addr = 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [DATA_W-1:0] data);
    host_bus.host_wr_valid = 1'b1;
    host_bus.host_addr     = 4'(addr);
    host_bus.host_wdata    = data;
    cyc();
    host_bus.host_wr_valid = 1'b0;
    model_write(addr, data);
  endtask

  task automatic host_read(input int addr, output logic [DATA_W-1:0] data);
    host_bus.host_rd_addr = 4'(addr);
    cyc();
    data = host_bus.host_rdata;
  endtask

  // One complete job starting from IDLE. dp_done is pulsed in RUN cycle k
  // (k=0: never, watchdog must expire). Optionally a host write in RUN cycle
  // wr_at and a stray start in RUN cycle st_at.
  task automatic run_job(input int k, input int wr_at, input int wa,
                         input logic [DATA_W-1:0] wd, input int st_at);
    logic [NUM_REGS*DATA_W-1:0] old_cfg;
    int last;
    old_cfg = packed_active();
    start = 1'b1;
    cyc();                                   // COMMIT
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL commit_busy: got %0b want 1", busy); end
    total++; if (host_bus.host_wr_ready !== 1'b0) begin bad++; $display("FAIL commit_ready: got %0b want 0", host_bus.host_wr_ready); end
    total++; if (dp_start !== 1'b0) begin bad++; $display("FAIL commit_dp_start: got %0b want 0", dp_start); end
    total++; if (cfg_out !== old_cfg) begin bad++; $display("FAIL commit_cfg_old: got %h want %h", cfg_out, old_cfg); end
    for (int i = 0; i < NUM_REGS; i++) exp_active[i] = exp_shadow[i];
    cyc();                                   // LAUNCH
    total++; if (dp_start !== 1'b1) begin bad++; $display("FAIL launch_dp_start: got %0b want 1", dp_start); end
    total++; if (cfg_out !== packed_active()) begin bad++; $display("FAIL launch_cfg: got %h want %h", cfg_out, packed_active()); end
    last = (k == 0) ? RUN_LIMIT : k;
    for (int r = 1; r <= last; r++) begin
      cyc();                                 // RUN cycle r
      host_bus.host_wr_valid = 1'b0; start = 1'b0; dp_done = 1'b0;
      total++; if ({dp_start, done, busy} !== 3'b001) begin bad++; $display("FAIL run_outputs r=%0d: got %b want 001", r, {dp_start, done, busy}); end
      if (r == wr_at) begin
        host_bus.host_wr_valid = 1'b1;
        host_bus.host_addr     = 4'(wa);
        host_bus.host_wdata    = wd;
        model_write(wa, wd);
      end
      if (r == st_at) begin start = 1'b1; exp_err_start = 1; end
      if (r == k) dp_done = 1'b1;
    end
    cyc();                                   // DONE
    host_bus.host_wr_valid = 1'b0; start = 1'b0; dp_done = 1'b0;
    if (k == 0) exp_timeout = 1;
    total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL done_pulse k=%0d: got %b want 11", k, {done, busy}); end
    total++; if (cfg_out !== packed_active()) begin bad++; $display("FAIL done_cfg_stable: got %h want %h", cfg_out, packed_active()); end
    cyc();                                   // back in IDLE
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL idle_after_done: got %b want 00", {done, busy}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL idle_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DATA_W-1:0] got, exp;
    rst = 1'b1; start = 1'b0; dp_done = 1'b0;
    host_bus.host_wr_valid = 1'b0; host_bus.host_addr = '0;
    host_bus.host_wdata = '0; host_bus.host_rd_addr = '0;
    cyc(); cyc();
    rst = 1'b0;
    model_reset();
    total++; if ({busy, done, dp_start} !== 3'b000) begin bad++; $display("FAIL reset_outputs: got %b want 000", {busy, done, dp_start}); end
    total++; if (host_bus.host_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", host_bus.host_wr_ready); end
    total++; if (cfg_out !== '0) begin bad++; $display("FAIL reset_cfg: got %h want 0", cfg_out); end
    total++; if (host_bus.host_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", host_bus.host_rdata); end
    for (int a = 0; a <= STAT_A; a++) begin
      if (a < NUM_REGS || a == STAT_A) begin
        exp_q.push_back((a == STAT_A) ? exp_status(0) : exp_shadow[a]);
        host_read(a, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL reset_read a=%0d: got %h want %h", a, got, exp); end
      end
    end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] got, old_v, new_v;
    for (int i = 0; i < NUM_REGS; i++) host_write(i, (i == 3) ? 16'h00A5 : DATA_W'($urandom));
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(exp_shadow[i]);
      host_read(i, got);
      old_v = exp_q.pop_front();
      total++; if (got !== old_v) begin bad++; $display("FAIL readback a=%0d: got %h want %h", i, got, old_v); end
    end
    // Read and write of the same register in one cycle returns the old value.
    old_v = exp_shadow[5];
    new_v = ~old_v;
    host_bus.host_wr_valid = 1'b1; host_bus.host_addr = 4'd5;
    host_bus.host_wdata = new_v; host_bus.host_rd_addr = 4'd5;
    cyc();
    host_bus.host_wr_valid = 1'b0;
    model_write(5, new_v);
    total++; if (host_bus.host_rdata !== old_v) begin bad++; $display("FAIL same_cycle_read: got %h want %h", host_bus.host_rdata, old_v); end
    host_read(5, got);
    total++; if (got !== new_v) begin bad++; $display("FAIL after_write_read: got %h want %h", got, new_v); end
  endtask

  task automatic test_basic_job();
    logic [DATA_W-1:0] got;
    run_job(8, 0, 0, '0, 0);
    total++; if (cfg_out[3*DATA_W +: DATA_W] !== 16'h00A5) begin bad++; $display("FAIL job_reg3: got %h want 00a5", cfg_out[3*DATA_W +: DATA_W]); end
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0)) begin bad++; $display("FAIL job_status: got %h want %h", got, exp_status(0)); end
  endtask

  task automatic test_run_write_start();
    logic [DATA_W-1:0] got;
    run_job(6, 2, 3, 16'h1234, 4);
    total++; if (cfg_out[3*DATA_W +: DATA_W] !== 16'h00A5) begin bad++; $display("FAIL run_write_cfg: got %h want 00a5", cfg_out[3*DATA_W +: DATA_W]); end
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[2] !== 1'b1) begin bad++; $display("FAIL err_start_set: got %h want %h", got, exp_status(0)); end
    run_job($urandom_range(1, RUN_LIMIT), 0, 0, '0, 0);
    total++; if (cfg_out[3*DATA_W +: DATA_W] !== 16'h1234) begin bad++; $display("FAIL next_commit_reg3: got %h want 1234", cfg_out[3*DATA_W +: DATA_W]); end
    host_write(STAT_A, 16'h0004);
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[2] !== 1'b0) begin bad++; $display("FAIL err_start_w1c: got %h want %h", got, exp_status(0)); end
  endtask

  task automatic test_bad_addr();
    logic [DATA_W-1:0] got, exp;
    host_write(9, DATA_W'($urandom));
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(exp_shadow[i]);
      host_read(i, got);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL bad_addr_shadow a=%0d: got %h want %h", i, got, exp); end
    end
    host_read(9, got);
    total++; if (got !== '0) begin bad++; $display("FAIL unmapped_read: got %h want 0", got); end
    dp_done = 1'b1;
    cyc();
    dp_done = 1'b0;
    exp_err_done = 1;
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[4:1] !== 4'b1001) begin bad++; $display("FAIL err_addr_done: got %h want %h", got, exp_status(0)); end
    host_write(STAT_A, 16'h0012);
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0)) begin bad++; $display("FAIL w1c_addr_done: got %h want %h", got, exp_status(0)); end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] got;
    run_job(0, 0, 0, '0, 0);
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[3] !== 1'b1) begin bad++; $display("FAIL timeout_set: got %h want %h", got, exp_status(0)); end
    host_write(STAT_A, 16'h0008);
    // dp_done on the very cycle the watchdog expires: completion wins.
    run_job(RUN_LIMIT, 0, 0, '0, 0);
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[3] !== 1'b0) begin bad++; $display("FAIL timeout_tie: got %h want %h", got, exp_status(0)); end
  endtask

  task automatic test_set_wins();
    logic [DATA_W-1:0] got;
    run_job(5, 3, STAT_A, 16'h0004, 3);
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0) || got[2] !== 1'b1) begin bad++; $display("FAIL set_beats_clear: got %h want %h", got, exp_status(0)); end
    host_write(STAT_A, 16'h001E);
  endtask

  task automatic test_reset_mid_run();
    logic [DATA_W-1:0] got, exp;
    for (int i = 0; i < NUM_REGS; i++) host_write(i, DATA_W'($urandom) | 16'h0001);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_active[i] = exp_shadow[i];
    cyc(); cyc(); cyc();                     // LAUNCH, RUN1, RUN2
    total++; if (cfg_out !== packed_active()) begin bad++; $display("FAIL pre_reset_cfg: got %h want %h", cfg_out, packed_active()); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_IDLE); end
    total++; if ({busy, done, dp_start} !== 3'b000) begin bad++; $display("FAIL abort_outputs: got %b want 000", {busy, done, dp_start}); end
    total++; if (cfg_out !== '0) begin bad++; $display("FAIL abort_cfg: got %h want 0", cfg_out); end
    for (int c = 0; c < 4; c++) begin
      cyc();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done c=%0d: got %0b want 0", c, done); end
    end
    for (int a = 0; a <= STAT_A; a++) begin
      if (a < NUM_REGS || a == STAT_A) begin
        exp_q.push_back((a == STAT_A) ? exp_status(0) : exp_shadow[a]);
        host_read(a, got);
        exp = exp_q.pop_front();
        total++; if (got !== exp) begin bad++; $display("FAIL abort_read a=%0d: got %h want %h", a, got, exp); end
      end
    end
    for (int i = 0; i < NUM_REGS; i++) host_write(i, DATA_W'($urandom));
    run_job($urandom_range(1, RUN_LIMIT), 0, 0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] got;
    for (int j = 0; j < 3; j++) begin
      host_write($urandom_range(0, NUM_REGS - 1), DATA_W'($urandom));
      host_write($urandom_range(0, NUM_REGS - 1), DATA_W'($urandom));
      run_job($urandom_range(1, RUN_LIMIT), $urandom_range(0, 3),
              $urandom_range(0, NUM_REGS - 1), DATA_W'($urandom), 0);
      // Start again in the first IDLE cycle after DONE.
      run_job($urandom_range(1, RUN_LIMIT), 0, 0, '0, 0);
    end
    host_read(STAT_A, got);
    total++; if (got !== exp_status(0)) begin bad++; $display("FAIL b2b_status: got %h want %h", got, exp_status(0)); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_basic_job();
    test_run_write_start();
    test_bad_addr();
    test_timeout();
    test_set_wins();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within 200000 ns");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/csr_seq_ctrl.md
Name: csr_seq_ctrl

Overview:
Configuration sequencer for the convolution datapath. Holds a host-writable shadow bank of NUM_REGS configuration registers (kernel size, stride, feature-map dims, base addresses). On a start request it commits shadow to an active bank in one cycle, launches the datapath, tracks completion with a watchdog, and reports status. Sits between the host/AXI-lite bridge and the conv engine's config inputs.

Parameters:
NUM_REGS, 8, number of config registers; must be ≤ 2^ADDR_W - 1.
DATA_W, 16, width of each config register.
ADDR_W, 4, host address width; address 2^ADDR_W-1 is the status register.
TIMEOUT_W, 16, watchdog counter width; timeout after 2^TIMEOUT_W-1 RUN cycles.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
host_wr_valid  in  1  host write request.
host_wr_ready  out  1  write accepted when valid&ready.
host_addr  in  ADDR_W  write address.
host_wdata  in  DATA_W  write data.
host_rd_addr  in  ADDR_W  read address.
host_rdata  out  DATA_W  read data, 1-cycle latency.
start  in  1  request to commit and launch (level, sampled per cycle).
busy  out  1  high from COMMIT through DONE inclusive.
done  out  1  one-cycle pulse at end of job.
dp_start  out  1  one-cycle launch pulse to datapath.
dp_done  in  1  datapath completion pulse.
cfg_out  out  NUM_REGS*DATA_W  active bank, reg i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset: one clock with rst=1 (sync, active-high). State IDLE; shadow and active banks zero; host_rdata, busy, done, dp_start, status bits all 0; host_wr_ready 1 after reset deassertion. rst mid-job aborts immediately; no done pulse.
- States: IDLE -> COMMIT -> LAUNCH -> RUN -> DONE -> IDLE.
  IDLE: start=1 -> COMMIT next cycle.
  COMMIT (1 cycle): active <= shadow; host_wr_ready=0.
  LAUNCH (1 cycle): dp_start=1; watchdog cleared.
  RUN: watchdog increments each cycle; dp_done=1 -> DONE; watchdog reaches all-ones with no dp_done -> DONE with timeout bit set.
  DONE (1 cycle): done=1 -> IDLE.
- Start-to-dp_start latency: 2 cycles (start sampled in cycle N, COMMIT N+1, dp_start N+2).
- Writes: accepted when host_wr_valid&host_wr_ready; addr < NUM_REGS updates shadow next edge. Shadow writes allowed in every state except COMMIT, so software may preload the next job while RUN. cfg_out changes only on COMMIT.
- Write to status address: W1C of error bits (data bit=1 clears that bit). Write to other addr ≥ NUM_REGS: dropped, err_addr set.
- Status register (DATA_W wide, unused bits 0): bit0 busy, bit1 err_addr, bit2 err_start, bit3 timeout, bit4 err_done.
- start=1 in any state other than IDLE: ignored, err_start set. start held high in DONE is an error; start in the IDLE cycle after DONE launches a new job.
- dp_done outside RUN: ignored, err_done set. dp_done and watchdog expiry in same cycle: dp_done wins, timeout not set.
- Error-set and W1C-clear of the same bit in the same cycle: set wins.
- Reads: host_rdata <= shadow[addr] for addr < NUM_REGS, status for status address, 0 otherwise; registered, one cycle after host_rd_addr. Read of a register written in the same cycle returns the old value.

Decomposition:
- Shared package csr_pkg: FSM state encoding (localparam, 3 bits), status bit indices, status-address constant function of ADDR_W.
- One sub-module: csr_bank (NUM_REGS×DATA_W register array with write-enable per entry), instantiated twice (shadow and active); the active copy uses a single broadcast load enable.

Test Plan:
- Reset then read addr 0..7 and 15 -> host_rdata 0 each, busy=0, host_wr_ready=1.
- Write reg3=0x00A5, start at cycle N -> cfg_out reg3=0x00A5 at N+2, dp_start pulse at N+2, busy high N+1..; dp_done at N+10 -> done pulse at N+11, busy low N+12.
- During RUN write reg3=0x1234, pulse start -> cfg_out still 0x00A5, status bit2=1; next job commits 0x1234; write 0x0004 to addr 15 clears bit2.
- Write addr 9 -> shadow unchanged, status bit1=1; pulse dp_done in IDLE -> status bit4=1.
- TIMEOUT_W=4, launch with no dp_done -> done pulse after 15 RUN cycles, status bit3=1.
- Assert rst during RUN -> next cycle IDLE, all banks 0, no done; new start works normally.
